// File: rtl/axis_slv_demux.sv
// Routes one upstream AXI-Stream to one of pUSER_PRJ_NUM project slave ports.
// Beats pass through a small FIFO; the destination is latched once per packet.
module axis_slv_demux #(
  parameter int pDATA_WIDTH   = 32,
  parameter int pUSER_PRJ_NUM = 4,
  parameter int pSEL_WIDTH    = 3,
  parameter int pFIFO_DEPTH   = 4
) (
  input  logic                               ASCLK,
  input  logic                               ARESET,
  input  logic [pSEL_WIDTH-1:0]              USER_PRJ_SEL,
  input  logic [pDATA_WIDTH-1:0]             as_tdata,
  input  logic [2:0]                         as_tid,
  input  logic                               as_tkeep,
  input  logic                               as_tlast,
  input  logic [3:0]                         as_tstrb,
  input  logic                               as_tvalid,
  output logic                               as_tready,
  output logic [pUSER_PRJ_NUM*pDATA_WIDTH-1:0] ss_tdata,
  output logic [pUSER_PRJ_NUM*3-1:0]         ss_tid,
  output logic [pUSER_PRJ_NUM-1:0]           ss_tkeep,
  output logic [pUSER_PRJ_NUM-1:0]           ss_tlast,
  output logic [pUSER_PRJ_NUM*4-1:0]         ss_tstrb,
  output logic [pUSER_PRJ_NUM-1:0]           ss_tvalid,
  input  logic [pUSER_PRJ_NUM-1:0]           ss_tready,
  output logic                               pkt_drop
);

  localparam int AW = $clog2(pFIFO_DEPTH);
  localparam int EW = pDATA_WIDTH + 9;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t                state_q, state_d;
  logic [pSEL_WIDTH-1:0] sel_q, sel_d;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           cnt_q;
  logic [EW-1:0]         mem_q [pFIFO_DEPTH];
  logic [EW-1:0]         head;
  logic                  empty, full, push, pop, head_last, sel_rdy, sel_ok;

  // Entry layout: {tdata, tid[2:0], tkeep, tlast, tstrb[3:0]}
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == (AW+1)'(pFIFO_DEPTH));
  assign as_tready = !full && !ARESET;
  assign push      = as_tvalid && as_tready;
  assign head      = mem_q[rd_ptr_q];
  assign head_last = head[4];
  assign sel_ok    = (32'(USER_PRJ_SEL) < 32'(pUSER_PRJ_NUM));

  always_ff @(posedge ASCLK) begin
    if (push) mem_q[wr_ptr_q] <= {as_tdata, as_tid, as_tkeep, as_tlast, as_tstrb};
  end

  always_ff @(posedge ASCLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      sel_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    sel_rdy = 1'b0;
    for (int i = 0; i < pUSER_PRJ_NUM; i++) begin
      if (sel_q == pSEL_WIDTH'(i)) sel_rdy = ss_tready[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pop      = 1'b0;
    pkt_drop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          sel_d   = USER_PRJ_SEL;
          state_d = sel_ok ? FWD : DROP;
        end
      end
      FWD: begin
        pop = !empty && sel_rdy;
        if (pop && head_last) state_d = IDLE;
      end
      DROP: begin
        pop = !empty;
        if (pop && head_last) begin
          pkt_drop = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the latched project sees the head; every other slice is held at zero.
  always_comb begin
    ss_tdata  = '0;
    ss_tid    = '0;
    ss_tkeep  = '0;
    ss_tlast  = '0;
    ss_tstrb  = '0;
    ss_tvalid = '0;
    for (int i = 0; i < pUSER_PRJ_NUM; i++) begin
      if (state_q == FWD && sel_q == pSEL_WIDTH'(i) && !empty) begin
        ss_tvalid[i]                             = 1'b1;
        ss_tdata[i*pDATA_WIDTH +: pDATA_WIDTH]   = head[EW-1:9];
        ss_tid[i*3 +: 3]                         = head[8:6];
        ss_tkeep[i]                              = head[5];
        ss_tlast[i]                              = head[4];
        ss_tstrb[i*4 +: 4]                       = head[3:0];
      end
    end
  end

endmodule

// File: tb/tb_axis_slv_demux.sv
// Randomized bench for axis_slv_demux: beats are expected in push order on the
// port named by their packet, with out-of-range packets vanishing behind pkt_drop.
module tb_axis_slv_demux;
  localparam int DW = 32;
  localparam int NP = 4;
  localparam int SW = 3;

  logic             ASCLK = 1'b0;
  logic             ARESET;
  logic [SW-1:0]    USER_PRJ_SEL;
  logic [DW-1:0]    as_tdata;
  logic [2:0]       as_tid;
  logic             as_tkeep, as_tlast;
  logic [3:0]       as_tstrb;
  logic             as_tvalid, as_tready;
  logic [NP*DW-1:0] ss_tdata;
  logic [NP*3-1:0]  ss_tid;
  logic [NP-1:0]    ss_tkeep, ss_tlast;
  logic [NP*4-1:0]  ss_tstrb;
  logic [NP-1:0]    ss_tvalid, ss_tready;
  logic             pkt_drop;

  axis_slv_demux #(.pDATA_WIDTH(DW), .pUSER_PRJ_NUM(NP), .pSEL_WIDTH(SW), .pFIFO_DEPTH(4)) dut (
    .ASCLK(ASCLK), .ARESET(ARESET), .USER_PRJ_SEL(USER_PRJ_SEL),
    .as_tdata(as_tdata), .as_tid(as_tid), .as_tkeep(as_tkeep), .as_tlast(as_tlast),
    .as_tstrb(as_tstrb), .as_tvalid(as_tvalid), .as_tready(as_tready),
    .ss_tdata(ss_tdata), .ss_tid(ss_tid), .ss_tkeep(ss_tkeep), .ss_tlast(ss_tlast),
    .ss_tstrb(ss_tstrb), .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .pkt_drop(pkt_drop)
  );

  always #5 ASCLK = ~ASCLK;

  typedef struct {
    logic [DW-1:0] data;
    logic [2:0]    tid;
    logic          keep;
    logic          last;
    logic [3:0]    strb;
    int            dest;
  } beat_t;

  beat_t       src_q[$];
  beat_t       exp_q[$];
  int          pop_cyc_q[$];
  int          n_chk = 0, n_fail = 0, cyc = 0, n_push = 0, n_drop = 0;
  int          t_push0 = -1, t_vld0 = -1;
  int          vld_pct = 100, rdy_pct = 100, sel_mid = -1;
  logic [NP-1:0] rdy_force_en = '1, rdy_force = '1;
  logic        started = 1'b0;
  logic [NP-1:0] prev_stall = '0;
  logic [40:0] prev_beat [NP];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [40:0] pack_slice(input int p);
    return {ss_tdata[p*DW +: DW], ss_tid[p*3 +: 3], ss_tkeep[p], ss_tlast[p], ss_tstrb[p*4 +: 4]};
  endfunction

  function automatic logic [40:0] pack_beat(input beat_t b);
    return {b.data, b.tid, b.keep, b.last, b.strb};
  endfunction

  task automatic add_pkt(input int dest, input int len, input logic [31:0] d0,
                         input logic [31:0] dstep, input bit with_last);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = d0 + i * dstep;
      b.tid  = 3'($urandom);
      b.keep = 1'($urandom);
      b.strb = 4'($urandom);
      b.last = with_last && (i == len - 1);
      b.dest = dest;
      src_q.push_back(b);
    end
  endtask

  // One cycle: drive inputs at the falling edge, check outputs against the
  // queue model, and account for the transfers that the next rising edge makes.
  task automatic step();
    logic [NP-1:0] allowed;
    logic [40:0]   idle_acc;
    beat_t         b;
    bit            done;
    @(negedge ASCLK);
    cyc++;
    for (int p = 0; p < NP; p++)
      ss_tready[p] = rdy_force_en[p] ? rdy_force[p] : ($urandom_range(99) < rdy_pct);
    if (src_q.size() > 0 && $urandom_range(99) < vld_pct) begin
      as_tvalid = 1'b1;
      as_tdata  = src_q[0].data;
      as_tid    = src_q[0].tid;
      as_tkeep  = src_q[0].keep;
      as_tlast  = src_q[0].last;
      as_tstrb  = src_q[0].strb;
    end else begin
      as_tvalid = 1'b0;
    end

    allowed = '0;
    if (exp_q.size() > 0 && exp_q[0].dest < NP) allowed[exp_q[0].dest] = 1'b1;
    chk("vld_mask", ss_tvalid & ~allowed, 0);
    idle_acc = '0;
    for (int p = 0; p < NP; p++) if (!allowed[p]) idle_acc |= pack_slice(p);
    chk("idle_zero", idle_acc, 0);

    for (int p = 0; p < NP; p++) begin
      if (prev_stall[p]) begin
        chk("hold_vld", ss_tvalid[p], 1);
        chk("hold_beat", pack_slice(p), prev_beat[p]);
      end
      prev_stall[p] = ss_tvalid[p] && !ss_tready[p];
      prev_beat[p]  = pack_slice(p);
    end

    if (|ss_tvalid) begin
      started = 1'b1;
      if (t_vld0 < 0) t_vld0 = cyc;
    end
    for (int p = 0; p < NP; p++) begin
      if (ss_tvalid[p] && ss_tready[p]) begin
        if (exp_q.size() == 0) chk("spurious_pop", 1, 0);
        else begin
          chk("pop_port", p, exp_q[0].dest);
          chk("pop_beat", pack_slice(p), pack_beat(exp_q[0]));
          if (exp_q[0].last) started = 1'b0;
          pop_cyc_q.push_back(cyc);
          void'(exp_q.pop_front());
        end
      end
    end

    if (pkt_drop) begin
      n_drop++;
      if (exp_q.size() == 0) chk("drop_spurious", 1, 0);
      else begin
        chk("drop_dest", exp_q[0].dest >= NP, 1);
        done = 1'b0;
        while (exp_q.size() > 0 && !done) begin
          b = exp_q.pop_front();
          done = b.last;
        end
        started = 1'b0;
      end
    end

    if (as_tvalid && as_tready) begin
      if (t_push0 < 0) t_push0 = cyc;
      exp_q.push_back(src_q.pop_front());
      n_push++;
    end

    // Present the oldest unfinished packet's destination until its first beat
    // shows up; after that the select is don't-care and gets scrambled.
    if (exp_q.size() > 0) begin
      if (started && sel_mid >= 0) USER_PRJ_SEL = SW'(sel_mid);
      else if (started)            USER_PRJ_SEL = SW'($urandom_range(7));
      else                         USER_PRJ_SEL = SW'(exp_q[0].dest);
    end else if (src_q.size() > 0) USER_PRJ_SEL = SW'(src_q[0].dest);
    else                           USER_PRJ_SEL = SW'($urandom_range(7));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < 3000) begin
      step();
      n++;
    end
    chk(tag, src_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    int base;
    ARESET = 1'b1;
    as_tvalid = 1'b0; as_tdata = '0; as_tid = '0; as_tkeep = 1'b0; as_tlast = 1'b0; as_tstrb = '0;
    ss_tready = '0; USER_PRJ_SEL = '0;
    #1;
    chk("rst_rdy", as_tready, 0);
    chk("rst_vld", ss_tvalid, 0);
    chk("rst_drop", pkt_drop, 0);
    repeat (3) @(negedge ASCLK);
    ARESET = 1'b0;
    #1;
    chk("post_rst_rdy", as_tready, 1);

    // 4-beat packet to project 2, first-beat latency of two cycles
    rdy_force_en = '1; rdy_force = '1; vld_pct = 100;
    t_push0 = -1; t_vld0 = -1;
    add_pkt(2, 4, 32'h11, 32'h11, 1);
    drain("t1_drain");
    chk("t1_lat", t_vld0 - t_push0, 2);

    // backpressure on project 1 fills the FIFO
    base = n_push;
    rdy_force = 4'b1101;
    add_pkt(1, 6, 32'hA0, 32'h1, 1);
    repeat (10) step();
    chk("t2_acc", n_push - base, 4);
    chk("t2_rdy", as_tready, 0);
    chk("t2_vld", ss_tvalid[1], 1);
    chk("t2_head", ss_tdata[63:32], 32'hA0);
    rdy_force = '1;
    drain("t2_drain");

    // select moves to 3 mid-packet; only the next packet follows it
    sel_mid = 3;
    add_pkt(0, 4, 32'hB0, 32'h1, 1);
    add_pkt(3, 3, 32'hC0, 32'h1, 1);
    drain("t3_drain");
    sel_mid = -1;

    // nonexistent project 5 is drained with a single pkt_drop pulse
    base = n_drop;
    add_pkt(5, 3, 32'hD0, 32'h1, 1);
    add_pkt(0, 2, 32'hE0, 32'h1, 1);
    drain("t4_drain");
    chk("t4_drops", n_drop - base, 1);

    // back-to-back single-beat packets alternating ports 0/1
    pop_cyc_q.delete();
    for (int k = 0; k < 6; k++) add_pkt(k % 2, 1, 32'hF0 + k, 32'h1, 1);
    drain("t5_drain");
    chk("t5_npop", pop_cyc_q.size(), 6);
    for (int i = 1; i < pop_cyc_q.size(); i++) chk("t5_gap", pop_cyc_q[i] - pop_cyc_q[i-1], 2);

    // asynchronous reset with a partial packet buffered
    rdy_force = '0;
    add_pkt(2, 3, 32'h60, 32'h1, 0);
    repeat (6) step();
    chk("t6_vld_pre", ss_tvalid[2], 1);
    #2 ARESET = 1'b1;
    #1;
    chk("t6_rdy", as_tready, 0);
    chk("t6_vld", ss_tvalid, 0);
    src_q.delete(); exp_q.delete(); started = 1'b0; prev_stall = '0; as_tvalid = 1'b0;
    repeat (2) step();
    ARESET = 1'b0;
    #1;
    chk("t6_rdy_rel", as_tready, 1);
    rdy_force = '1; t_push0 = -1; t_vld0 = -1;
    add_pkt(3, 2, 32'h70, 32'h1, 1);
    drain("t6_drain");
    chk("t6_lat", t_vld0 - t_push0, 2);

    // random traffic, random destinations (including drops), random stalls
    rdy_force_en = '0; vld_pct = 70; rdy_pct = 60;
    base = n_drop;
    for (int k = 0; k < 40; k++)
      add_pkt($urandom_range(7), $urandom_range(1, 5), $urandom, 32'(k + 1), 1);
    drain("t7_drain");
    vld_pct = 100; rdy_pct = 100;
    for (int k = 0; k < 20; k++)
      add_pkt($urandom_range(7), $urandom_range(1, 3), $urandom, 32'h3, 1);
    drain("t8_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
